// File: rtl/zero_count_normalizer.sv
// Two-stage leading/trailing zero counter and normalizer with valid/ready flow control.
// S1 registers per-nibble counts; S2 picks the first non-zero nibble and shifts.
module zero_count_normalizer #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_zeros,
  output logic             out_all_zeros,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
);

  localparam int NIB = WIDTH / 4;

  logic             v1_q, v1_d, v2_q, v2_d;
  logic             load1, load2;
  logic [2*NIB-1:0] lc_in, lc_q, lc_d;
  logic [NIB-1:0]   zf_in, zf_q, zf_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic             mode1_q, mode1_d;

  logic [CW-1:0]    cnt_s2;
  logic             found_s2;
  logic             az_s2;
  logic [WIDTH-1:0] shifted_s2;

  logic [CW-1:0]    zeros2_q, zeros2_d;
  logic             az2_q, az2_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic             mode2_q, mode2_d;

  assign load2    = v1_q && (!v2_q || out_ready);
  assign in_ready = !v1_q || !v2_q || out_ready;
  assign load1    = in_valid && in_ready;

  // Local count per nibble: priority from the nibble MSB in mode 0, from its LSB in mode 1.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    logic [3:0] nib;
    logic [1:0] cnt;
    assign nib = in_data[4*gi +: 4];
    always_comb begin
      cnt = 2'd3;
      if (!in_mode) begin
        casez (nib)
          4'b1???: cnt = 2'd0;
          4'b01??: cnt = 2'd1;
          4'b001?: cnt = 2'd2;
          default: cnt = 2'd3;
        endcase
      end else begin
        casez (nib)
          4'b???1: cnt = 2'd0;
          4'b??10: cnt = 2'd1;
          4'b?100: cnt = 2'd2;
          default: cnt = 2'd3;
        endcase
      end
    end
    assign lc_in[2*gi +: 2] = cnt;
    assign zf_in[gi]        = (nib == 4'd0);
  end

  always_comb begin
    v1_d    = load1 ? 1'b1 : (load2 ? 1'b0 : v1_q);
    lc_d    = load1 ? lc_in   : lc_q;
    zf_d    = load1 ? zf_in   : zf_q;
    data1_d = load1 ? in_data : data1_q;
    mode1_d = load1 ? in_mode : mode1_q;
  end

  // k counts nibbles from the scan start, so the count is simply 4*k + local count.
  always_comb begin
    cnt_s2   = '0;
    found_s2 = 1'b0;
    for (int k = 0; k < NIB; k++) begin
      if (!found_s2) begin
        if (mode1_q) begin
          if (!zf_q[k]) begin
            found_s2 = 1'b1;
            cnt_s2   = CW'(4 * k) + CW'(lc_q[2*k +: 2]);
          end
        end else if (!zf_q[NIB-1-k]) begin
          found_s2 = 1'b1;
          cnt_s2   = CW'(4 * k) + CW'(lc_q[2*(NIB-1-k) +: 2]);
        end
      end
    end
    az_s2      = &zf_q;
    shifted_s2 = mode1_q ? (data1_q >> cnt_s2) : (data1_q << cnt_s2);
    if (az_s2) shifted_s2 = '0;
  end

  always_comb begin
    v2_d     = load2 ? 1'b1 : (out_ready ? 1'b0 : v2_q);
    zeros2_d = load2 ? cnt_s2     : zeros2_q;
    az2_d    = load2 ? az_s2      : az2_q;
    data2_d  = load2 ? shifted_s2 : data2_q;
    mode2_d  = load2 ? mode1_q    : mode2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      lc_q     <= '0;
      zf_q     <= '0;
      data1_q  <= '0;
      mode1_q  <= 1'b0;
      v2_q     <= 1'b0;
      zeros2_q <= '0;
      az2_q    <= 1'b0;
      data2_q  <= '0;
      mode2_q  <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      lc_q     <= lc_d;
      zf_q     <= zf_d;
      data1_q  <= data1_d;
      mode1_q  <= mode1_d;
      v2_q     <= v2_d;
      zeros2_q <= zeros2_d;
      az2_q    <= az2_d;
      data2_q  <= data2_d;
      mode2_q  <= mode2_d;
    end
  end

  assign out_valid     = v2_q;
  assign out_zeros     = zeros2_q;
  assign out_all_zeros = az2_q;
  assign out_data      = data2_q;
  assign out_mode      = mode2_q;

endmodule

// File: tb/tb_zero_count_normalizer.sv
// Directed and randomized checks of zero_count_normalizer at WIDTH=32.
`timescale 1ns/1ps
module tb_zero_count_normalizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_mode;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_all_zeros, out_mode;
  logic [4:0]  out_zeros;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [31:0] d; logic m; } item_t;
  item_t sb[$];

  zero_count_normalizer #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_zeros(out_zeros),
    .out_all_zeros(out_all_zeros), .out_data(out_data), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0] ez, input logic eaz,
                           input logic [31:0] ed, input logic em);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_zeros"}, out_zeros, ez);
    check({tag, "_az"}, out_all_zeros, eaz);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_mode"}, out_mode, em);
  endtask

  // Word presented before edge N is in S1 after N and in S2 after N+1.
  task automatic run_vec(input string tag, input logic [31:0] d, input logic m,
                         input logic [4:0] ez, input logic eaz, input logic [31:0] ed);
    @(negedge clk);
    in_data = d; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    check_out(tag, ez, eaz, ed, m);
    $display("vec %s data=%08h mode=%0d zeros=%0d az=%0d out=%08h", tag, d, m, out_zeros, out_all_zeros, out_data);
  endtask

  // Bit-by-bit scan, independent of the nibble structure.
  function automatic void ref_model(input logic [31:0] d, input logic m,
                                    output logic [4:0] z, output logic az, output logic [31:0] o);
    az = (d == 32'd0);
    z  = 5'd0;
    o  = 32'd0;
    if (!az) begin
      if (!m) begin
        for (int i = 31; i >= 0; i--) if (d[i]) begin z = 5'(31 - i); break; end
        o = d << z;
      end else begin
        for (int i = 0; i < 32; i++) if (d[i]) begin z = 5'(i); break; end
        o = d >> z;
      end
    end
  endfunction

  initial begin
    logic [4:0]  rz;
    logic        raz, hold;
    logic [31:0] rd, w;
    item_t       it;
    int          sh;

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_zeros", out_zeros, 5'd0);
    check("rst_az", out_all_zeros, 1'b0);
    check("rst_data", out_data, 32'd0);
    check("rst_mode", out_mode, 1'b0);
    reset_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1'b1);

    run_vec("lz_bit16", 32'h0001_0000, 1'b0, 5'd15, 1'b0, 32'h8000_0000);
    run_vec("tz_bit16", 32'h0001_0000, 1'b1, 5'd16, 1'b0, 32'h0000_0001);
    run_vec("lz_msb",   32'h8000_0000, 1'b0, 5'd0,  1'b0, 32'h8000_0000);
    run_vec("zero_m0",  32'h0000_0000, 1'b0, 5'd0,  1'b1, 32'h0000_0000);
    run_vec("zero_m1",  32'h0000_0000, 1'b1, 5'd0,  1'b1, 32'h0000_0000);
    run_vec("lz_lsb",   32'h0000_0001, 1'b0, 5'd31, 1'b0, 32'h8000_0000);
    run_vec("tz_nib",   32'h0000_00F0, 1'b1, 5'd4,  1'b0, 32'h0000_000F);
    run_vec("lz_nib",   32'h00F0_0000, 1'b0, 5'd8,  1'b0, 32'hF000_0000);
    run_vec("tz_msb",   32'h8000_0000, 1'b1, 5'd31, 1'b0, 32'h0000_0001);

    // Back-to-back stream: one result per cycle, no bubbles.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check_out("stream", 5'(33 - c), 1'b0, 32'h8000_0000, 1'b0);
        $display("stream result %0d zeros=%0d", c - 2, out_zeros);
      end
      if (c < 4) begin
        w = 32'd1 << c;
        in_data = w; in_mode = 1'b0; in_valid = 1'b1;
      end else in_valid = 1'b0;
    end
    @(negedge clk);
    check("stream_end", out_valid, 1'b0);

    // Stall: two words held, third word waits at the input.
    out_ready = 1'b0;
    in_data = 32'h0000_0010; in_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("stall_rdy0", in_ready, 1'b1);
    in_data = 32'h0000_0030;
    @(negedge clk);
    in_data = 32'h0000_0500; in_mode = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_in_ready", in_ready, 1'b0);
      check_out("stall_hold", 5'd27, 1'b0, 32'h8000_0000, 1'b0);
      $display("stall cycle %0d in_ready=%0d zeros=%0d", c, in_ready, out_zeros);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("release_rdy", in_ready, 1'b1);
    check_out("drain_a", 5'd27, 1'b0, 32'h8000_0000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("drain_b", 5'd26, 1'b0, 32'hC000_0000, 1'b0);
    @(negedge clk);
    check_out("drain_c", 5'd8, 1'b0, 32'h0000_0005, 1'b1);
    @(negedge clk);
    check("drain_empty", out_valid, 1'b0);
    $display("drain complete");

    // Reset with both stages full.
    out_ready = 1'b0;
    in_data = 32'h0000_0100; in_mode = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_data = 32'h0000_0200;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_mode", out_mode, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_zeros", out_zeros, 5'd0);
    check("arst_data", out_data, 32'd0);
    check("arst_mode", out_mode, 1'b0);
    $display("async reset applied out_valid=%0d", out_valid);
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    #1 check("post_rst_ready", in_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_stale", out_valid, 1'b0);
    end

    // Random traffic against the bit-scan model; source holds a word until accepted.
    hold = 1'b0;
    for (int c = 0; c < 620; c++) begin
      @(negedge clk);
      if (!hold) begin
        if (c < 600 && $urandom_range(0, 3) != 0) begin
          in_mode = 1'($urandom_range(0, 1));
          sh = $urandom_range(0, 32);
          w = $urandom();
          in_data = in_mode ? (w << sh) : (w >> sh);
          in_valid = 1'b1;
        end else in_valid = 1'b0;
      end
      out_ready = (c >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #4;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("rnd_spurious", out_valid, 1'b0);
        else begin
          it = sb.pop_front();
          ref_model(it.d, it.m, rz, raz, rd);
          check("rnd_zeros", out_zeros, rz);
          check("rnd_az", out_all_zeros, raz);
          check("rnd_data", out_data, rd);
          check("rnd_mode", out_mode, it.m);
          $display("rnd in=%08h mode=%0d zeros=%0d out=%08h", it.d, it.m, out_zeros, out_data);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{d: in_data, m: in_mode});
        hold = 1'b0;
      end else hold = in_valid;
    end
    check("rnd_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
